// File: rtl/stpu_mem_arbiter_pkg.sv
// Shared types and constants for the STPU memory-port arbiter.
// The state encoding and counter width are fixed here so the SOPC and the arbiter agree on them.
package stpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2,
        ArbDone  = 2'd3
    } arb_state_t;

    localparam int ArbLatW = 3;
    localparam logic [3:0] SelAll = 4'b1111;

    // Data wins a tie unless it won the previous grant.
    function automatic logic arb_pick_d(input logic if_req, input logic d_req, input logic last_d);
        return d_req & (~if_req | ~last_d);
    endfunction

endpackage

// File: rtl/stpu_mem_arbiter.sv
// Shares the single synchronous memory port between instruction fetch and the MEM-stage data path.
// One transaction at a time; read data returns MEM_LAT cycles after the memory strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ArbIdle  | no transaction; grant the winning requester on this edge
// ArbIssue | mem_ce high for one cycle with the registered command
// ArbWait  | counting down the memory read latency
// ArbDone  | one-cycle ack to the granted requester, no new grant
module stpu_mem_arbiter
    import stpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stallreq
);

    localparam logic [ArbLatW-1:0] LatInit = ArbLatW'(MEM_LAT - 1);
    localparam logic [ArbLatW-1:0] CntOne  = ArbLatW'(1);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [ArbLatW-1:0] cnt_q;
    logic               last_d_q;
    logic               gnt_d_q;
    logic               grant;
    logic               pick_d;
    logic               capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ArbIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        capture = 1'b0;
        if_ack  = 1'b0;
        d_ack   = 1'b0;
        pick_d  = arb_pick_d(if_req, d_req, last_d_q);
        case (state_q)
            ArbIdle: begin
                if (if_req || d_req) begin
                    grant   = 1'b1;
                    state_d = ArbIssue;
                end
            end
            // mem_we is only ever high during ISSUE, so it doubles as the write flag here.
            ArbIssue: state_d = mem_we ? ArbDone : ArbWait;
            ArbWait: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ArbDone;
                end
            end
            ArbDone: begin
                if_ack  = ~gnt_d_q;
                d_ack   = gnt_d_q;
                state_d = ArbIdle;
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
            gnt_d_q   <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_ce <= 1'b0;
            mem_we <= 1'b0;
            if (grant) begin
                mem_ce   <= 1'b1;
                gnt_d_q  <= pick_d;
                last_d_q <= pick_d;
                if (pick_d) begin
                    mem_we    <= d_we;
                    mem_sel   <= d_sel;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_sel  <= SelAll;
                    mem_addr <= if_addr;
                end
            end

            if (state_q == ArbIssue) begin
                cnt_q <= LatInit;
            end else if (state_q == ArbWait && cnt_q != '0) begin
                cnt_q <= cnt_q - CntOne;
            end

            if (capture) begin
                if (gnt_d_q) begin
                    d_rdata <= mem_rdata;
                end else begin
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign stallreq = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_stpu_mem_arbiter.sv
// Bench for stpu_mem_arbiter: one instance per memory latency, random fetch/data traffic,
// a latency-accurate memory model and a transaction-level reference of the arbiter.
module tb_stpu_mem_arbiter;

    localparam int NLAT = 4;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = (i == 4) ? 32'h3401_1100 : (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
        return w;
    endfunction

    for (genvar gi = 0; gi < NLAT; gi++) begin : g_lat
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 7;

        logic        rst = 1'b1;
        logic        if_req = 1'b0;
        logic [31:0] if_addr = '0;
        logic [31:0] if_rdata;
        logic        if_ack;
        logic        d_req = 1'b0;
        logic        d_we = 1'b0;
        logic [3:0]  d_sel = '0;
        logic [31:0] d_addr = '0;
        logic [31:0] d_wdata = '0;
        logic [31:0] d_rdata;
        logic        d_ack;
        logic        mem_ce;
        logic        mem_we;
        logic [3:0]  mem_sel;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        stallreq;
        string       pre;

        stpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_rdata (if_rdata),
            .if_ack   (if_ack),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_sel    (d_sel),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_rdata  (d_rdata),
            .d_ack    (d_ack),
            .mem_ce   (mem_ce),
            .mem_we   (mem_we),
            .mem_sel  (mem_sel),
            .mem_addr (mem_addr),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata),
            .stallreq (stallreq)
        );

        // Memory: samples the strobe, presents read data for exactly the one cycle ending at
        // sample edge + L, and random junk otherwise.
        logic [31:0] ram [64];
        bit          ram_init = 1'b0;
        bit          pend_v = 1'b0;
        int unsigned pend_due = 0;
        logic [31:0] pend_data = '0;

        always @(posedge clk) begin
            if (!ram_init) begin
                for (int i = 0; i < 64; i++) ram[i] = init_word(i);
                ram_init = 1'b1;
            end
            if (mem_ce) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    pend_v    = 1'b1;
                    pend_due  = cyc + L;
                    pend_data = ram[mem_addr[7:2]];
                end
            end
            if (pend_v && pend_due == cyc + 1) begin
                mem_rdata <= pend_data;
                pend_v = 1'b0;
            end else begin
                mem_rdata <= $urandom;
            end
        end

        // Reference: one transaction at a time, occupying fixed edge offsets from its grant.
        logic [31:0] mdl [64];
        bit          mdl_init = 1'b0;
        bit          busy, g_d, g_we, last_d, pick;
        int unsigned free_edge, done_edge;
        logic [31:0] g_data;
        logic        e_ce, e_we, e_ifack, e_dack;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wdata, e_ifrd, e_drd;

        always @(posedge clk or negedge rst) begin
            if (!mdl_init) begin
                for (int i = 0; i < 64; i++) mdl[i] = init_word(i);
                mdl_init = 1'b1;
            end
            if (!rst) begin
                busy = 0; last_d = 0; g_d = 0; g_we = 0; free_edge = 0; done_edge = 0;
                g_data = '0;
                e_ce = 0; e_we = 0; e_ifack = 0; e_dack = 0;
                e_sel = '0; e_addr = '0; e_wdata = '0; e_ifrd = '0; e_drd = '0;
            end else begin
                e_ce = 0; e_we = 0; e_ifack = 0; e_dack = 0;
                if (busy && cyc == done_edge) begin
                    if (g_d) e_dack = 1; else e_ifack = 1;
                    if (!g_we) begin
                        if (g_d) e_drd = g_data; else e_ifrd = g_data;
                    end
                    busy = 0;
                    free_edge = cyc + 2;
                end else if (!busy && cyc >= free_edge && (if_req || d_req)) begin
                    pick   = d_req && (!if_req || !last_d);
                    last_d = pick;
                    g_d    = pick;
                    if (pick) begin
                        g_we = d_we; e_addr = d_addr; e_sel = d_sel; e_wdata = d_wdata;
                        if (d_we) begin
                            for (int b = 0; b < 4; b++)
                                if (d_sel[b]) mdl[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                        end else begin
                            g_data = mdl[d_addr[7:2]];
                        end
                    end else begin
                        g_we = 0; e_addr = if_addr; e_sel = 4'hF;
                        g_data = mdl[if_addr[7:2]];
                    end
                    e_ce = 1; e_we = g_we; busy = 1;
                    done_edge = cyc + 1 + (g_we ? 0 : L);
                end
            end
        end

        always @(negedge clk) begin
            if (cyc > 0) begin
                check_val({pre, "ctrl{ce,we,if_ack,d_ack,stall}"},
                          {27'd0, mem_ce, mem_we, if_ack, d_ack, stallreq},
                          {27'd0, e_ce, e_we, e_ifack, e_dack,
                           (if_req & ~e_ifack) | (d_req & ~e_dack)});
                check_val({pre, "mem_addr"}, mem_addr, e_addr);
                check_val({pre, "mem_sel"}, {28'd0, mem_sel}, {28'd0, e_sel});
                check_val({pre, "mem_wdata"}, mem_wdata, e_wdata);
                check_val({pre, "if_rdata"}, if_rdata, e_ifrd);
                check_val({pre, "d_rdata"}, d_rdata, e_drd);
            end
        end

        task automatic chk_zero(input string t);
            check_val({pre, t, "ctrl"}, {27'd0, mem_ce, mem_we, if_ack, d_ack, stallreq}, 32'd0);
            check_val({pre, t, "mem_addr"}, mem_addr, 32'd0);
            check_val({pre, t, "mem_sel"}, {28'd0, mem_sel}, 32'd0);
            check_val({pre, t, "mem_wdata"}, mem_wdata, 32'd0);
            check_val({pre, t, "if_rdata"}, if_rdata, 32'd0);
            check_val({pre, t, "d_rdata"}, d_rdata, 32'd0);
        endtask

        task automatic run_if(input int ntx, input bit directed);
            int w;
            for (int t = 0; t < ntx; t++) begin
                if (t > 0 && $urandom_range(0, 3) == 0) begin
                    if_req = 1'b0;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
                end
                if_req  = 1'b1;
                if_addr = (directed && t == 0) ? 32'h0000_0010 : $urandom;
                w = 0;
                do begin @(posedge clk); #2; w++; end while (!if_ack && w < 40);
                if (!if_ack) begin
                    check_val({pre, "if_ack_timeout"}, {31'd0, if_ack}, 32'd1);
                    break;
                end
                @(posedge clk); #2;
            end
            if_req = 1'b0;
        endtask

        task automatic run_d(input int ntx, input bit directed);
            int w;
            for (int t = 0; t < ntx; t++) begin
                if (t > 0 && $urandom_range(0, 3) == 0) begin
                    d_req = 1'b0;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
                end
                d_req = 1'b1;
                if (directed && t == 0) begin
                    d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
                end else begin
                    d_we = 1'($urandom_range(0, 1)); d_sel = 4'($urandom_range(0, 15));
                    d_addr = $urandom; d_wdata = $urandom;
                end
                w = 0;
                do begin @(posedge clk); #2; w++; end while (!d_ack && w < 40);
                if (!d_ack) begin
                    check_val({pre, "d_ack_timeout"}, {31'd0, d_ack}, 32'd1);
                    break;
                end
                @(posedge clk); #2;
            end
            d_req = 1'b0;
        endtask

        initial begin
            pre = $sformatf("L%0d_", L);
            #1 rst = 1'b0;
            #1 chk_zero("reset_");
            repeat (2) @(posedge clk);
            #2 rst = 1'b1;

            fork
                run_if(40, 1'b1);
                run_d(40, 1'b1);
            join

            // Abandon a read while the latency counter is running.
            repeat (3) begin @(posedge clk); #2; end
            if_req  = 1'b1;
            if_addr = $urandom;
            @(posedge clk); #2;
            @(posedge clk); #2;
            rst    = 1'b0;
            if_req = 1'b0;
            #1 chk_zero("midread_");
            repeat (3) begin @(posedge clk); #2; end
            rst = 1'b1;

            fork
                run_if(40, 1'b0);
                run_d(40, 1'b0);
            join
            repeat (4) begin @(posedge clk); #2; end
            n_done++;
        end
    end

    initial begin
        int w;
        w = 0;
        while (n_done < NLAT && w < 20000) begin
            @(posedge clk);
            w++;
        end
        check_val("all_instances_done", 32'(n_done), 32'(NLAT));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stpu_mem_arbiter.md
# stpu_mem_arbiter

Two-requester arbiter sharing the SOPC's single synchronous memory port between the instruction-fetch path and the data (MEM-stage) path of the STPU core. It grants one requester at a time and drives the memory port for that requester. It waits a fixed memory latency, returns read data with a one-cycle ack, and raises a stall request to the pipeline controller while any request is outstanding. It sits between `stpu` and the on-chip RAM inside `stpu_sopc`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from the memory sampling edge to valid `mem_rdata`; legal range 1..7
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous and active-low
- `if_req`  in  1  fetch request level, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched word
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `d_req`  in  1  data request level, held until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_sel`  in  4  byte enables
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read data
- `d_ack`  out  1  one-cycle completion pulse for data
- `mem_ce`  out  1  memory strobe, high for exactly one cycle per transaction
- `mem_we`  out  1  memory write enable
- `mem_sel`  out  4  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `stallreq`  out  1  pipeline stall request

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any request is high, register the winner's command into `mem_*` and go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Single request: that requester wins.
  - Both requesting: round-robin on a `last_d` flag. Data wins unless the previous grant was data, in which case fetch wins.
  - `last_d` resets to 0, so data wins the first tie.
- **Fetch command mapping**
  - `mem_we`=0, `mem_sel`=4'b1111, `mem_addr`=`if_addr`.
  - Addresses pass through unmodified.
- **ISSUE**
  - `mem_ce`=1 for this cycle only.
  - Read: go to WAIT with `cnt`=`MEM_LAT`-1.
  - Write: go to DONE.
- **WAIT**
  - `cnt`≠0: decrement.
  - `cnt`=0: capture `mem_rdata` into the granted requester's rdata register, then go to DONE.
- **DONE**
  - Granted requester's ack=1 for this one cycle.
  - No new grant is made in DONE; go to IDLE.
- **Outside ISSUE**
  - `mem_ce`=0 and `mem_we`=0.
  - `mem_addr`, `mem_sel` and `mem_wdata` hold their last values.
- **Read data registers**
  - `if_rdata` and `d_rdata` hold until that requester's next read completes.
  - Writes never change `d_rdata`.
- **Stall request**
  - `stallreq` = (`if_req` & ~`if_ack`) | (`d_req` & ~`d_ack`), combinational.
- **Requester contract**
  - A requester drops its request, or presents a new command, at the edge that ends its ack cycle.
  - A request never drops before its ack; such behaviour is undefined.
  - Command inputs are sampled only at the grant edge.
- **Reset**
  - State → IDLE, `cnt`→0, `last_d`→0.
  - All outputs → 0, including `if_rdata` and `d_rdata`.
  - An in-flight transaction is abandoned and no ack is issued.

## Timing
- Read: request sampled in IDLE at edge k.
  - `mem_ce` high during cycle k+1.
  - Data captured at edge k+1+`MEM_LAT`.
  - Ack high during cycle k+2+`MEM_LAT`.
  - Earliest next grant at edge k+3+`MEM_LAT`.
- Write: ack high during cycle k+2; earliest next grant at edge k+3.
- Read throughput: one transaction per `MEM_LAT`+3 cycles.
- The loser of a tie is granted at the first IDLE edge after the winner's DONE. Worst-case wait is one full transaction.

## Structure
- `Defines.vh` gets:
  - FSM encodings `ArbIdle`, `ArbIssue`, `ArbWait`, `ArbDone` (2 bits).
  - `ArbLatW` = 3 for the counter width.
- No sub-module: a single module containing FSM, counter, round-robin flag and output registers.
- Instantiated in `stpu_sopc` between the core's instruction/data ports and the RAM.

## Test plan
- **Reset mid-read**
  - Stimulus: `MEM_LAT`=2; assert `rst`=0 during WAIT.
  - Required: all outputs 0 immediately; no ack follows; a fresh fetch after release completes normally.
- **Single fetch**
  - Stimulus: `MEM_LAT`=1; `if_req` with `if_addr`=0x0000_0010; memory returns 0x3401_1100.
  - Required: `mem_ce` only in cycle k+1; `if_ack` and `if_rdata`=0x3401_1100 in cycle k+3; `stallreq` high cycles k..k+2.
- **Data write**
  - Stimulus: `d_we`=1, `d_sel`=4'b0011, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF.
  - Required: one `mem_ce`/`mem_we` cycle with these values; `d_ack` at k+2; `d_rdata` unchanged.
- **Tie and alternation**
  - Stimulus: both requests held continuously from reset.
  - Required: grants alternate d, if, d, if; each ack arrives in its own DONE cycle.
- **Latency sweep**
  - Stimulus: `MEM_LAT`=1, 3, 7 reads.
  - Required: ack exactly `MEM_LAT`+2 cycles after the grant edge; data captured at the correct edge.
- **Back-to-back fetch**
  - Stimulus: `if_req` re-asserted with a new address in the cycle after ack.
  - Required: no duplicate issue of the old address; second `mem_ce` at earliest legal edge.
